// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only have B/H/W encodings; loads additionally allow BU/HU.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 > F3_W);
    end
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_if.sv
// Core-side request/response and data-memory bus of the load/store unit.
`default_nettype none

interface lsu_if;
  logic        i_req;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [31:0] o_rdata;
  logic [15:0] o_mem_addr;
  logic        o_mem_wren;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;

  modport master (
    output i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
    input  o_busy, o_done, o_err, o_rdata, o_mem_addr, o_mem_wren, o_mem_wdata
  );

  modport slave (
    input  i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
    output o_busy, o_done, o_err, o_rdata, o_mem_addr, o_mem_wren, o_mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/lsu_align.sv
// Byte/half lane handling: load extraction, sub-word store merge, alignment check.
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_mem_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_word,
  output logic [31:0] o_store_word,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0: w_byte = i_mem_word[7:0];
      2'd1: w_byte = i_mem_word[15:8];
      2'd2: w_byte = i_mem_word[23:16];
      2'd3: w_byte = i_mem_word[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_addr_lo[1] ? i_mem_word[31:16] : i_mem_word[15:0];
  end

  always_comb begin
    o_load_word = 32'h0;
    case (i_funct3)
      F3_B:    o_load_word = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_word = {24'h0, w_byte};
      F3_H:    o_load_word = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_word = {16'h0, w_half};
      F3_W:    o_load_word = i_mem_word;
      default: o_load_word = 32'h0;
    endcase
  end

  // Untouched lanes keep the value just read from memory.
  always_comb begin
    o_store_word = i_mem_word;
    case (i_funct3)
      F3_B: begin
        case (i_addr_lo)
          2'd0: o_store_word[7:0]   = i_wdata[7:0];
          2'd1: o_store_word[15:8]  = i_wdata[7:0];
          2'd2: o_store_word[23:16] = i_wdata[7:0];
          2'd3: o_store_word[31:24] = i_wdata[7:0];
          default: o_store_word = i_mem_word;
        endcase
      end
      F3_H: begin
        if (i_addr_lo[1]) begin
          o_store_word[31:16] = i_wdata[15:0];
        end else begin
          o_store_word[15:0] = i_wdata[15:0];
        end
      end
      F3_W:    o_store_word = i_wdata;
      default: o_store_word = i_mem_word;
    endcase
  end

  always_comb begin
    o_misalign = 1'b0;
    case (i_funct3)
      F3_H, F3_HU: o_misalign = i_addr_lo[0];
      F3_W:        o_misalign = |i_addr_lo;
      default:     o_misalign = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// Load/store initiator: request latching, RD/WR sequencing and registered responses.
`default_nettype none

module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE = 32'h0000_2000,
  parameter logic [31:0] DMEM_SIZE = 32'h0000_2000
) (
  input  logic  i_clk,
  input  logic  i_rst,
  lsu_if.slave  bus
);

  lsu_state_e  r_state;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_wdata;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [15:0] r_mem_addr;
  logic        r_wren;
  logic [31:0] r_mem_wdata;

  logic        w_idle;
  logic [2:0]  w_f3;
  logic [1:0]  w_addr_lo;
  logic [31:0] w_load_word;
  logic [31:0] w_store_word;
  logic        w_misalign;
  logic        w_range_ok;
  logic        w_req_err;

  // In IDLE the aligner checks the incoming request; afterwards it works on the latched one.
  assign w_idle    = (r_state == IDLE);
  assign w_f3      = w_idle ? bus.i_funct3   : r_f3;
  assign w_addr_lo = w_idle ? bus.i_addr[1:0] : r_addr_lo;

  lsu_align u_align (
    .i_funct3     (w_f3),
    .i_addr_lo    (w_addr_lo),
    .i_mem_word   (bus.i_mem_rdata),
    .i_wdata      (r_wdata),
    .o_load_word  (w_load_word),
    .o_store_word (w_store_word),
    .o_misalign   (w_misalign)
  );

  assign w_range_ok = ((bus.i_addr & ~(DMEM_SIZE - 32'd1)) == DMEM_BASE);
  assign w_req_err  = f3_illegal(bus.i_we, bus.i_funct3) | w_misalign | ~w_range_ok;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_f3        <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_wdata     <= 32'h0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
      r_mem_addr  <= 16'h0;
      r_wren      <= 1'b0;
      r_mem_wdata <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_wren <= 1'b0;
          if (bus.i_req) begin
            r_we       <= bus.i_we;
            r_f3       <= bus.i_funct3;
            r_addr_lo  <= bus.i_addr[1:0];
            r_wdata    <= bus.i_wdata;
            r_mem_addr <= {bus.i_addr[15:2], 2'b00};
            if (w_req_err) begin
              r_err   <= 1'b1;
              r_rdata <= 32'h0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else if (bus.i_we && (bus.i_funct3 == F3_W)) begin
              r_mem_wdata <= bus.i_wdata;
              r_wren      <= 1'b1;
              r_state     <= WR;
            end else begin
              r_state <= RD;
            end
          end
        end
        RD: begin
          if (r_we) begin
            r_mem_wdata <= w_store_word;
            r_wren      <= 1'b1;
            r_state     <= WR;
          end else begin
            r_rdata <= w_load_word;
            r_err   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        WR: begin
          r_wren  <= 1'b0;
          r_rdata <= 32'h0;
          r_err   <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_busy      = ~w_idle;
  assign bus.o_done      = r_done;
  assign bus.o_err       = r_err;
  assign bus.o_rdata     = r_rdata;
  assign bus.o_mem_addr  = r_mem_addr;
  assign bus.o_mem_wdata = r_mem_wdata;
  // Gating with reset keeps a write in flight from landing on the reset edge.
  assign bus.o_mem_wren  = r_wren & i_rst;

endmodule

`default_nettype wire
